// File: rtl/fpnew_unit_arbiter.sv
// fpnew_unit_arbiter: shares one in-order iterative FP unit between NumReq
// requesters. One grant per cycle onto the unit input handshake; the grant
// index is queued in an in-flight ID FIFO and used to steer each response
// back to its requester.
// Build option: define FPNEW_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise the lowest valid index wins (fixed priority, no pointer register).

// Per-requester steering: ready on the request side, valid on the response side.
module fpnew_unit_arbiter_lane (
  input  logic is_gnt,
  input  logic issue_rdy,
  input  logic is_head,
  input  logic rsp_fwd,
  output logic req_ready,
  output logic rsp_valid
);
  assign req_ready = is_gnt & issue_rdy;
  assign rsp_valid = is_head & rsp_fwd;
endmodule

module fpnew_unit_arbiter #(
  parameter int NumReq      = 2,
  parameter int DataWidth   = 64,
  parameter int MaxInflight = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic [NumReq-1:0]                  req_valid_i,
  output logic [NumReq-1:0]                  req_ready_o,
  input  logic [NumReq-1:0][DataWidth-1:0]   req_data_i,
  output logic                               unit_valid_o,
  input  logic                               unit_ready_i,
  output logic [DataWidth-1:0]               unit_data_o,
  input  logic                               unit_rsp_valid_i,
  output logic                               unit_rsp_ready_o,
  input  logic [DataWidth-1:0]               unit_rsp_data_i,
  output logic [NumReq-1:0]                  rsp_valid_o,
  input  logic [NumReq-1:0]                  rsp_ready_i,
  output logic [DataWidth-1:0]               rsp_data_o,
  output logic                               flush_o,
  output logic                               busy_o
);

  localparam int IdW   = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int AddrW = (MaxInflight > 1) ? $clog2(MaxInflight) : 1;
  localparam int CntW  = $clog2(MaxInflight) + 1;

  typedef logic [IdW-1:0]   id_t;
  typedef logic [AddrW-1:0] addr_t;

  id_t             id_mem [MaxInflight];
  addr_t           wr_ptr, rd_ptr;
  logic [CntW-1:0] cnt;

  logic fifo_full, fifo_empty;
  logic can_issue, any_valid, issue_rdy, push, pop;
  logic rsp_route, rsp_fwd;
  id_t  gnt, head;

  // Pointer advance with wrap at MaxInflight (works for depth 1 too).
  function automatic addr_t inc_ptr(input addr_t p);
    return (p == addr_t'(MaxInflight - 1)) ? '0 : p + addr_t'(1);
  endfunction

  assign fifo_full  = (cnt == CntW'(MaxInflight));
  assign fifo_empty = (cnt == '0);

  // Full blocks issue even when a pop lands in the same cycle, so the
  // response handshake never feeds the request side combinationally.
  assign can_issue  = ~fifo_full & ~flush_i;
  assign any_valid  = |req_valid_i;
  assign issue_rdy  = can_issue & any_valid & unit_ready_i;

  assign unit_valid_o = can_issue & any_valid;
  assign unit_data_o  = req_data_i[gnt];
  assign push         = unit_valid_o & unit_ready_i;

  assign head             = id_mem[rd_ptr];
  assign rsp_route        = ~fifo_empty & ~flush_i;
  assign rsp_fwd          = unit_rsp_valid_i & rsp_route;
  assign unit_rsp_ready_o = rsp_route & rsp_ready_i[head];
  assign pop              = unit_rsp_valid_i & unit_rsp_ready_o;
  assign rsp_data_o       = unit_rsp_data_i;

  assign flush_o = flush_i;
  assign busy_o  = ~fifo_empty;

`ifdef FPNEW_ARB_ROUND_ROBIN_EN
  id_t rr_ptr;

  // Round-robin: first valid index at or after rr_ptr, wrapping. Scan from
  // the far end so the nearest offset overwrites last and wins.
  always_comb begin
    id_t idx;
    idx = '0;
    gnt = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      idx = id_t'((int'(rr_ptr) + i) % NumReq);
      if (req_valid_i[idx]) gnt = idx;
    end
  end

  // Pointer moves only on an accepted issue, so a stalled grant is held.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      rr_ptr <= '0;
    else if (flush_i) rr_ptr <= '0;
    else if (push)    rr_ptr <= (gnt == id_t'(NumReq - 1)) ? '0 : gnt + id_t'(1);
  end
`else
  // Fixed priority: lowest valid index wins.
  always_comb begin
    id_t idx;
    idx = '0;
    gnt = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      idx = id_t'(i);
      if (req_valid_i[idx]) gnt = idx;
    end
  end
`endif

  // ID storage; contents are don't-care while the slot is not occupied.
  always_ff @(posedge clk_i) begin
    if (push) id_mem[wr_ptr] <= gnt;
  end

  // FIFO pointers and in-flight count; flush drops everything in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= inc_ptr(wr_ptr);
      if (pop)  rd_ptr <= inc_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + CntW'(1);
        2'b01:   cnt <= cnt - CntW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Per-requester ready/valid steering.
  for (genvar i = 0; i < NumReq; i++) begin : g_lane
    fpnew_unit_arbiter_lane u_lane (
      .is_gnt    (gnt == id_t'(i)),
      .issue_rdy (issue_rdy),
      .is_head   (head == id_t'(i)),
      .rsp_fwd   (rsp_fwd),
      .req_ready (req_ready_o[i]),
      .rsp_valid (rsp_valid_o[i])
    );
  end

endmodule

// File: tb/tb_fpnew_unit_arbiter.sv
// Self-checking bench for fpnew_unit_arbiter (NumReq=2, MaxInflight=4).
// Expected grant IDs are queued when a request is issued and popped when the
// matching response comes back.
module tb_fpnew_unit_arbiter;
  localparam int NumReq      = 2;
  localparam int DataWidth   = 64;
  localparam int MaxInflight = 4;
`ifdef FPNEW_ARB_ROUND_ROBIN_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic                             clk_i = 1'b0;
  logic                             rst_ni;
  logic                             flush_i;
  logic [NumReq-1:0]                req_valid_i;
  logic [NumReq-1:0]                req_ready_o;
  logic [NumReq-1:0][DataWidth-1:0] req_data_i;
  logic                             unit_valid_o;
  logic                             unit_ready_i;
  logic [DataWidth-1:0]             unit_data_o;
  logic                             unit_rsp_valid_i;
  logic                             unit_rsp_ready_o;
  logic [DataWidth-1:0]             unit_rsp_data_i;
  logic [NumReq-1:0]                rsp_valid_o;
  logic [NumReq-1:0]                rsp_ready_i;
  logic [DataWidth-1:0]             rsp_data_o;
  logic                             flush_o;
  logic                             busy_o;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  fpnew_unit_arbiter #(
    .NumReq(NumReq), .DataWidth(DataWidth), .MaxInflight(MaxInflight)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_data_i(req_data_i),
    .unit_valid_o(unit_valid_o), .unit_ready_i(unit_ready_i), .unit_data_o(unit_data_o),
    .unit_rsp_valid_i(unit_rsp_valid_i), .unit_rsp_ready_o(unit_rsp_ready_o),
    .unit_rsp_data_i(unit_rsp_data_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .flush_o(flush_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i); #1;
  endtask

  task automatic do_flush;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset;
    int id;
    logic [DataWidth-1:0] d;
    rst_ni = 1'b0; flush_i = 1'b0; req_valid_i = '0; req_data_i = '0;
    unit_ready_i = 1'b0; unit_rsp_valid_i = 1'b0; unit_rsp_data_i = '0; rsp_ready_i = '0;
    #12;
    checks++; if (unit_valid_o !== 1'b0) begin errors++; $display("FAIL reset_unit_valid got %b want 0", unit_valid_o); end
    checks++; if (req_ready_o !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b want 00", req_ready_o); end
    checks++; if (rsp_valid_o !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b want 00", rsp_valid_o); end
    checks++; if (unit_rsp_ready_o !== 1'b0) begin errors++; $display("FAIL reset_unit_rsp_ready got %b want 0", unit_rsp_ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL reset_flush_o got %b want 0", flush_o); end
    tick();
    rst_ni = 1'b1;
    tick();
    req_valid_i = 2'b01; req_data_i[0] = 64'h0123_4567_89ab_cdef; unit_ready_i = 1'b1;
    #1;
    checks++; if (unit_valid_o !== 1'b1) begin errors++; $display("FAIL first_unit_valid got %b want 1", unit_valid_o); end
    checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL first_req_ready got %b want 01", req_ready_o); end
    checks++; if (unit_data_o !== 64'h0123_4567_89ab_cdef) begin errors++; $display("FAIL first_unit_data got %h want 0123456789abcdef", unit_data_o); end
    exp_q.push_back(0);
    tick();
    req_valid_i = '0;
    #1;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL first_busy got %b want 1", busy_o); end
    d = 64'hfeed_0000_0000_0001;
    unit_rsp_valid_i = 1'b1; unit_rsp_data_i = d; rsp_ready_i = 2'b11;
    #1;
    id = exp_q.pop_front();
    checks++; if (rsp_valid_o !== 2'(1 << id)) begin errors++; $display("FAIL first_rsp_valid got %b want %b", rsp_valid_o, 2'(1 << id)); end
    checks++; if (rsp_data_o !== d) begin errors++; $display("FAIL first_rsp_data got %h want %h", rsp_data_o, d); end
    checks++; if (unit_rsp_ready_o !== 1'b1) begin errors++; $display("FAIL first_rsp_ready got %b want 1", unit_rsp_ready_o); end
    tick();
    unit_rsp_valid_i = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL first_idle got %b want 0", busy_o); end
  endtask

  // Both requesters valid for 4 issues; leaves the FIFO full.
  task automatic test_fairness;
    int g;
    do_flush();
    req_valid_i = 2'b11; unit_ready_i = 1'b1; rsp_ready_i = 2'b11;
    req_data_i[0] = 64'haaaa_0000_0000_0000; req_data_i[1] = 64'hbbbb_0000_0000_0001;
    for (int k = 0; k < 4; k++) begin
      #1;
      g = RrEn ? (k % 2) : 0;
      checks++; if (req_ready_o !== 2'(1 << g)) begin errors++; $display("FAIL fair_grant%0d got %b want %b", k, req_ready_o, 2'(1 << g)); end
      checks++; if (unit_data_o !== req_data_i[g]) begin errors++; $display("FAIL fair_data%0d got %h want %h", k, unit_data_o, req_data_i[g]); end
      exp_q.push_back(g);
      tick();
    end
  endtask

  task automatic test_full;
    int id;
    logic [DataWidth-1:0] d;
    #1;
    checks++; if (req_ready_o !== 2'b00) begin errors++; $display("FAIL full_req_ready got %b want 00", req_ready_o); end
    checks++; if (unit_valid_o !== 1'b0) begin errors++; $display("FAIL full_unit_valid got %b want 0", unit_valid_o); end
    d = {$urandom, $urandom};
    unit_rsp_valid_i = 1'b1; unit_rsp_data_i = d;
    #1;
    id = exp_q.pop_front();
    checks++; if (rsp_valid_o !== 2'(1 << id)) begin errors++; $display("FAIL full_pop_valid got %b want %b", rsp_valid_o, 2'(1 << id)); end
    checks++; if (unit_rsp_ready_o !== 1'b1) begin errors++; $display("FAIL full_pop_ready got %b want 1", unit_rsp_ready_o); end
    checks++; if (unit_valid_o !== 1'b0) begin errors++; $display("FAIL full_no_issue_on_pop got %b want 0", unit_valid_o); end
    tick();
    unit_rsp_valid_i = 1'b0;
    #1;
    checks++; if (unit_valid_o !== 1'b1) begin errors++; $display("FAIL full_resume_valid got %b want 1", unit_valid_o); end
    checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL full_resume_grant got %b want 01", req_ready_o); end
    exp_q.push_back(0);
    tick();
    req_valid_i = '0;
    for (int k = 0; k < 4; k++) begin
      d = {$urandom, $urandom};
      unit_rsp_valid_i = 1'b1; unit_rsp_data_i = d;
      #1;
      id = exp_q.pop_front();
      checks++; if (rsp_valid_o !== 2'(1 << id)) begin errors++; $display("FAIL full_drain_valid%0d got %b want %b", k, rsp_valid_o, 2'(1 << id)); end
      checks++; if (rsp_data_o !== d) begin errors++; $display("FAIL full_drain_data%0d got %h want %h", k, rsp_data_o, d); end
      tick();
    end
    unit_rsp_valid_i = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL full_drained_busy got %b want 0", busy_o); end
  endtask

  // Issue order 1,0,1; first response stalled by rsp_ready_i[1]=0.
  task automatic test_routing;
    int ord[3] = '{1, 0, 1};
    int id;
    logic [DataWidth-1:0] d;
    do_flush();
    unit_ready_i = 1'b1; rsp_ready_i = 2'b11;
    for (int k = 0; k < 3; k++) begin
      req_valid_i = 2'(1 << ord[k]);
      req_data_i[ord[k]] = {$urandom, $urandom};
      #1;
      checks++; if (req_ready_o !== 2'(1 << ord[k])) begin errors++; $display("FAIL route_issue%0d got %b want %b", k, req_ready_o, 2'(1 << ord[k])); end
      exp_q.push_back(ord[k]);
      tick();
    end
    req_valid_i = '0;
    d = 64'hd0d0_d0d0_d0d0_d0d0;
    unit_rsp_valid_i = 1'b1; unit_rsp_data_i = d; rsp_ready_i = 2'b01;
    for (int s = 0; s < 2; s++) begin
      #1;
      checks++; if (unit_rsp_ready_o !== 1'b0) begin errors++; $display("FAIL route_stall_ready%0d got %b want 0", s, unit_rsp_ready_o); end
      checks++; if (rsp_valid_o !== 2'b10) begin errors++; $display("FAIL route_stall_valid%0d got %b want 10", s, rsp_valid_o); end
      tick();
    end
    rsp_ready_i = 2'b11;
    for (int k = 0; k < 3; k++) begin
      d = {$urandom, $urandom};
      unit_rsp_data_i = d;
      #1;
      id = exp_q.pop_front();
      checks++; if (rsp_valid_o !== 2'(1 << id)) begin errors++; $display("FAIL route_rsp_valid%0d got %b want %b", k, rsp_valid_o, 2'(1 << id)); end
      checks++; if (rsp_data_o !== d) begin errors++; $display("FAIL route_rsp_data%0d got %h want %h", k, rsp_data_o, d); end
      checks++; if (unit_rsp_ready_o !== 1'b1) begin errors++; $display("FAIL route_rsp_ready%0d got %b want 1", k, unit_rsp_ready_o); end
      tick();
    end
    unit_rsp_valid_i = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL route_idle got %b want 0", busy_o); end
  endtask

  task automatic test_flush;
    do_flush();
    req_valid_i = 2'b01; unit_ready_i = 1'b1; rsp_ready_i = 2'b11;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(0);
      tick();
    end
    flush_i = 1'b1; unit_rsp_valid_i = 1'b1; unit_rsp_data_i = {$urandom, $urandom};
    #1;
    checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL flush_fwd got %b want 1", flush_o); end
    checks++; if (unit_valid_o !== 1'b0) begin errors++; $display("FAIL flush_unit_valid got %b want 0", unit_valid_o); end
    checks++; if (req_ready_o !== 2'b00) begin errors++; $display("FAIL flush_req_ready got %b want 00", req_ready_o); end
    checks++; if (rsp_valid_o !== 2'b00) begin errors++; $display("FAIL flush_rsp_valid got %b want 00", rsp_valid_o); end
    checks++; if (unit_rsp_ready_o !== 1'b0) begin errors++; $display("FAIL flush_rsp_ready got %b want 0", unit_rsp_ready_o); end
    tick();
    flush_i = 1'b0; req_valid_i = '0;
    exp_q.delete();
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy_o); end
    checks++; if (rsp_valid_o !== 2'b00) begin errors++; $display("FAIL flush_stray_valid got %b want 00", rsp_valid_o); end
    checks++; if (unit_rsp_ready_o !== 1'b0) begin errors++; $display("FAIL flush_stray_ready got %b want 0", unit_rsp_ready_o); end
    tick();
    unit_rsp_valid_i = 1'b0;
  endtask

  // Count held at 2 while issuing and popping every cycle; pointers wrap.
  task automatic test_back_to_back;
    int r, id;
    logic [DataWidth-1:0] d;
    do_flush();
    unit_ready_i = 1'b1; rsp_ready_i = 2'b11;
    for (int k = 0; k < 2; k++) begin
      req_valid_i = 2'(1 << k);
      exp_q.push_back(k);
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      r = k % 2;
      req_valid_i = 2'(1 << r);
      req_data_i[r] = {$urandom, $urandom};
      d = {$urandom, $urandom};
      unit_rsp_valid_i = 1'b1; unit_rsp_data_i = d;
      #1;
      checks++; if (req_ready_o !== 2'(1 << r)) begin errors++; $display("FAIL b2b_grant%0d got %b want %b", k, req_ready_o, 2'(1 << r)); end
      checks++; if (unit_data_o !== req_data_i[r]) begin errors++; $display("FAIL b2b_data%0d got %h want %h", k, unit_data_o, req_data_i[r]); end
      id = exp_q.pop_front();
      checks++; if (rsp_valid_o !== 2'(1 << id)) begin errors++; $display("FAIL b2b_rsp%0d got %b want %b", k, rsp_valid_o, 2'(1 << id)); end
      checks++; if (unit_rsp_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_rsp_ready%0d got %b want 1", k, unit_rsp_ready_o); end
      exp_q.push_back(r);
      tick();
    end
    req_valid_i = '0;
    for (int k = 0; k < 2; k++) begin
      d = {$urandom, $urandom};
      unit_rsp_data_i = d;
      #1;
      id = exp_q.pop_front();
      checks++; if (rsp_valid_o !== 2'(1 << id)) begin errors++; $display("FAIL b2b_drain%0d got %b want %b", k, rsp_valid_o, 2'(1 << id)); end
      tick();
    end
    unit_rsp_valid_i = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", busy_o); end
  endtask

  task automatic test_reset_midflight;
    do_flush();
    req_valid_i = 2'b10; unit_ready_i = 1'b1;
    tick();
    tick();
    req_valid_i = '0;
    #1;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b want 1", busy_o); end
    rst_ni = 1'b0; unit_rsp_valid_i = 1'b1;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy_o); end
    checks++; if (rsp_valid_o !== 2'b00) begin errors++; $display("FAIL midrst_rsp_valid got %b want 00", rsp_valid_o); end
    exp_q.delete();
    tick();
    rst_ni = 1'b1; unit_rsp_valid_i = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_full();
    test_routing();
    test_flush();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
